entrada_digito: RTL and testbench
=================================

Name: entrada_digito

Overview:
- Front-end digit-entry stage directly upstream of the sequence-lock FSM.
- Synchronises and debounces the raw "insere" pushbutton, samples the 4-bit switch value once per clean press, and emits it as a one-cycle-valid digit.
- Counts accepted digits toward a complete code (N_DIGITOS) so the lock stage consumes exactly one digit per press.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required on press and on release (must be ≥2; silicon builds override with a large value).
- N_DIGITOS, 6, digits in a complete code; digit counter saturates here.
- CNT_W, $clog2(N_DIGITOS+1), width of contagem.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- insere  input  1  raw pushbutton, active-high, asynchronous, bouncy.
- numero  input  4  raw switch value, asynchronous.
- limpa  input  1  synchronous clear of the digit counter, active-high.
- digito  output  4  last accepted digit, held until the next acceptance.
- valido  output  1  one-cycle pulse: digito is new this cycle.
- contagem  output  CNT_W  accepted digits since reset/limpa, saturating at N_DIGITOS.
- completa  output  1  high while contagem == N_DIGITOS.
- erro  output  1  one-cycle pulse on a rejected digit (BCD_FILTRO_EN only; otherwise tied 0).

Behaviour:
- Reset (reset=0, async):
  - digito=0, valido=0, contagem=0, completa=0, erro=0.
  - Synchronisers cleared; FSM=OCIOSO; debounce counter=0.
- Synchronisers: two-flop synchroniser on insere (ins_s) and on each numero bit (num_s). All logic uses only the synchronised signals.
- FSM states:
  - OCIOSO: ins_s=1 → FILTRA, cnt=0.
  - FILTRA:
    - ins_s=0 → OCIOSO (glitch discarded, no output).
    - Else cnt+1.
    - At cnt==DEBOUNCE_CYCLES-1 with ins_s=1 → EMITE, and digito<=num_s on that same edge.
  - EMITE: one cycle; unconditionally → SOLTAR, cnt=0.
  - SOLTAR:
    - ins_s=1 → cnt=0, stay.
    - ins_s=0 → cnt+1.
    - At cnt==DEBOUNCE_CYCLES-1 with ins_s=0 → OCIOSO.
- valido is registered and high exactly while FSM=EMITE.
- Latency: if edge E0 is the first to sample insere=1 and insere stays high, valido is high in the cycle after edge E0+DEBOUNCE_CYCLES+2. With the default, that is the cycle after E6.
- A button held indefinitely yields exactly one valido. A new press is accepted only after a clean release.
- Digit counter:
  - Increments on the edge entering EMITE.
  - Saturates at N_DIGITOS. Presses beyond that still pulse valido/digito; contagem holds.
  - completa = (contagem==N_DIGITOS), registered with contagem.
  - limpa alone → contagem=0 on the next edge.
  - limpa on the same edge as entry to EMITE → contagem=1 (the new digit counts).
- numero changing during FILTRA: only the value of num_s on the edge entering EMITE is captured.
- Reset mid-operation: outputs clear immediately. If insere is still held at reset release, the press is treated as new and yields one valido after full debounce.

Optional Feature:
- Macro: BCD_FILTRO_EN.
- Defined:
  - On the edge entering EMITE, if num_s > 9: digito unchanged, valido stays 0, erro=1 for that one cycle, contagem unchanged.
  - FSM still passes through EMITE and SOLTAR.
- Undefined: all values 0–15 are accepted; erro is constant 0.

Test Plan:
- Hold after reset, DEBOUNCE_CYCLES=4, numero=5, insere held 20 cycles from E0 → single valido pulse in the cycle after E6; digito=5; contagem=1; no further pulse while held.
- Bounce: insere 1,1,0,1,1,0 then 0 → no valido; contagem=0; FSM returns to OCIOSO.
- Full code: six clean presses with 5,9,0,2,8,1 → six valido pulses with matching digito; contagem 1..6; completa=1 after the 6th. A 7th press (numero=3) → valido, digito=3, contagem stays 6.
- Clear: limpa=1 on the edge entering EMITE with contagem=6 → contagem=1, completa=0. limpa alone → contagem=0 next cycle.
- Async reset: reset=0 mid-FILTRA → all outputs 0 without a clock edge. Release with insere still held → exactly one valido after the full debounce latency.
- BCD filter, numero=12:
  - With BCD_FILTRO_EN: erro pulses 1 cycle, valido=0, digito and contagem unchanged.
  - Without it: valido pulses, digito=12, erro=0.

Source files
------------

// File: rtl/entrada_digito.sv
// entrada_digito: digit-entry front end for the sequence lock.
//
// Synchronises and debounces the raw "insere" pushbutton. On each clean
// press it samples the synchronised 4-bit switch value once, presents it on
// digito with a one-cycle valido pulse, and counts accepted digits toward a
// complete code.
//
// Optional build macro: BCD_FILTRO_EN
//   When defined, a sampled value above 9 is rejected. digito and contagem
//   keep their values, valido stays low and erro pulses for one cycle.
//   When undefined, every value 0-15 is accepted and erro is constant 0.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   insere   in   raw pushbutton, active-high, asynchronous and bouncy
//   numero   in   raw 4-bit switch value, asynchronous
//   limpa    in   synchronous clear of the digit counter
//   digito   out  last accepted digit, held until the next acceptance
//   valido   out  one-cycle pulse: digito is new this cycle
//   contagem out  accepted digits since reset/limpa, saturating at N_DIGITOS
//   completa out  high while contagem == N_DIGITOS
//   erro     out  one-cycle pulse on a rejected digit (filter builds only)
module entrada_digito #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,  // must be >= 2
  parameter int unsigned N_DIGITOS       = 6,
  parameter int unsigned CNT_W           = $clog2(N_DIGITOS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             insere,
  input  logic [3:0]       numero,
  input  logic             limpa,
  output logic [3:0]       digito,
  output logic             valido,
  output logic [CNT_W-1:0] contagem,
  output logic             completa,
  output logic             erro
);

  localparam int unsigned      DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_DIGITOS);

  typedef enum logic [1:0] {
    StOcioso,
    StFiltra,
    StEmite,
    StSoltar
  } estado_e;

  // Two-flop synchronisers; nothing downstream looks at the raw inputs.
  logic       ins_meta_q, ins_s_q;
  logic [3:0] num_meta_q, num_s_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ins_meta_q <= 1'b0;
      ins_s_q    <= 1'b0;
      num_meta_q <= 4'd0;
      num_s_q    <= 4'd0;
    end else begin
      ins_meta_q <= insere;
      ins_s_q    <= ins_meta_q;
      num_meta_q <= numero;
      num_s_q    <= num_meta_q;
    end
  end

  estado_e         estado_q, estado_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            entra_emite;

  always_comb begin
    estado_d    = estado_q;
    cnt_d       = cnt_q;
    entra_emite = 1'b0;
    unique case (estado_q)
      StOcioso: begin
        if (ins_s_q) begin
          estado_d = StFiltra;
          cnt_d    = '0;
        end
      end
      StFiltra: begin
        if (!ins_s_q) begin
          estado_d = StOcioso;  // glitch, discard
        end else if (cnt_q == DB_LAST) begin
          estado_d    = StEmite;
          entra_emite = 1'b1;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
      StEmite: begin
        estado_d = StSoltar;
        cnt_d    = '0;
      end
      StSoltar: begin
        // Any bounce back to pressed restarts the release window.
        if (ins_s_q) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          estado_d = StOcioso;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
      default: begin
        estado_d = StOcioso;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q <= StOcioso;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
    end
  end

  // Acceptance decision, taken on the edge that enters StEmite.
  logic aceita, rejeita;

`ifdef BCD_FILTRO_EN
  always_comb begin
    rejeita = entra_emite && (num_s_q > 4'd9);
    aceita  = entra_emite && !rejeita;
  end
`else
  always_comb begin
    rejeita = 1'b0;
    aceita  = entra_emite;
  end
`endif

  logic [3:0]       digito_q, digito_d;
  logic             valido_q, erro_q, completa_q;
  logic [CNT_W-1:0] contagem_q, contagem_d;

  always_comb begin
    digito_d   = aceita ? num_s_q : digito_q;
    contagem_d = contagem_q;
    if (aceita && limpa) begin
      contagem_d = CNT_W'(1);  // the digit arriving with the clear still counts
    end else if (aceita) begin
      if (contagem_q != CNT_MAX) begin
        contagem_d = contagem_q + CNT_W'(1);
      end
    end else if (limpa) begin
      contagem_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digito_q   <= 4'd0;
      valido_q   <= 1'b0;
      erro_q     <= 1'b0;
      contagem_q <= '0;
      completa_q <= 1'b0;
    end else begin
      digito_q   <= digito_d;
      valido_q   <= aceita;
      erro_q     <= rejeita;
      contagem_q <= contagem_d;
      completa_q <= (contagem_d == CNT_MAX);
    end
  end

  assign digito   = digito_q;
  assign valido   = valido_q;
  assign erro     = erro_q;
  assign contagem = contagem_q;
  assign completa = completa_q;

endmodule

// File: tb/tb_entrada_digito.sv
module tb_entrada_digito;

  localparam int DB    = 4;
  localparam int ND    = 6;
  localparam int CNT_W = $clog2(ND + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             insere;
  logic [3:0]       numero;
  logic             limpa;
  logic [3:0]       digito;
  logic             valido;
  logic [CNT_W-1:0] contagem;
  logic             completa;
  logic             erro;

  entrada_digito #(
    .DEBOUNCE_CYCLES(DB),
    .N_DIGITOS      (ND)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .insere  (insere),
    .numero  (numero),
    .limpa   (limpa),
    .digito  (digito),
    .valido  (valido),
    .contagem(contagem),
    .completa(completa),
    .erro    (erro)
  );

  always #5 clk = ~clk;

`ifdef BCD_FILTRO_EN
  localparam bit FILTRO = 1'b1;
`else
  localparam bit FILTRO = 1'b0;
`endif

  typedef struct {
    bit         rej;
    logic [3:0] dig;
    int         cnt;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         model_cnt = 0;
  logic [3:0] model_dig = 4'd0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference: one clean press yields one digit event; its effect on the
  // code counter follows from counting, clearing and saturating rules.
  function automatic exp_t model_press(input logic [3:0] d, input bit clr);
    exp_t e;
    e.rej = FILTRO && (d > 4'd9);
    if (!e.rej) begin
      model_dig = d;
      if (clr) model_cnt = 1;
      else if (model_cnt < ND) model_cnt++;
    end else if (clr) begin
      model_cnt = 0;
    end
    e.dig = model_dig;
    e.cnt = model_cnt;
    return e;
  endfunction

  // Monitor: every valido/erro pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (reset === 1'b1 && (valido === 1'b1 || erro === 1'b1)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_valido", int'(valido), int'(!e.rej));
        chk("mon_erro", int'(erro), int'(e.rej));
        chk("mon_digito", int'(digito), int'(e.dig));
        chk("mon_contagem", int'(contagem), e.cnt);
        chk("mon_completa", int'(completa), int'(e.cnt == ND));
      end
    end
  end

  // Clean press: insere rises just before edge E0; numero wanders early in
  // the debounce window and settles to d before it is captured.
  task automatic press(input logic [3:0] d, input bit clr, input int extra,
                       input bit bounce, input bit lat);
    exp_t e;
    e = model_press(d, clr);
    sb.push_back(e);
    numero = 4'($urandom_range(0, 15));
    insere = 1'b1;
    for (int k = 0; k < 7 + extra; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k < 3) numero = 4'($urandom_range(0, 15));
      if (k == 3) numero = d;
      if (k == 5) limpa = clr;
      if (k == 6) limpa = 1'b0;
      if (lat && k == 5) chk("latency_early", int'(valido | erro), 0);
      if (lat && k == 6) chk("latency_pulse", int'(valido | erro), 1);
    end
    insere = 1'b0;
    if (bounce) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      insere = 1'b1;
      repeat ($urandom_range(1, 2)) @(negedge clk);
      insere = 1'b0;
    end
    repeat (DB + 4) @(negedge clk);
  endtask

  task automatic glitch();
    insere = 1'b1;
    repeat ($urandom_range(1, DB)) @(negedge clk);
    insere = 1'b0;
    repeat (DB + 4) @(negedge clk);
  endtask

  task automatic clear_alone();
    limpa = 1'b1;
    @(negedge clk);
    limpa = 1'b0;
    model_cnt = 0;
    chk("limpa_contagem", int'(contagem), 0);
    chk("limpa_completa", int'(completa), 0);
  endtask

  initial begin
    logic [6:0] bounce_seq;
    logic [3:0] code [6];
    exp_t       e;
    reset  = 1'b0;
    insere = 1'b0;
    numero = 4'd0;
    limpa  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_digito", int'(digito), 0);
    chk("rst_valido", int'(valido), 0);
    chk("rst_contagem", int'(contagem), 0);
    chk("rst_completa", int'(completa), 0);
    chk("rst_erro", int'(erro), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Held button: one pulse after full latency, none while still held.
    press(4'd5, 1'b0, 13, 1'b0, 1'b1);
    chk("hold_digito", int'(digito), 5);
    chk("hold_contagem", int'(contagem), 1);

    // Bounce shorter than the debounce window: nothing accepted.
    bounce_seq = 7'b1101100;
    for (int i = 6; i >= 0; i--) begin
      insere = bounce_seq[i];
      @(negedge clk);
    end
    repeat (DB + 4) @(negedge clk);
    chk("bounce_contagem", int'(contagem), 1);

    clear_alone();

    // Full code, then one past saturation.
    code = '{4'd5, 4'd9, 4'd0, 4'd2, 4'd8, 4'd1};
    for (int i = 0; i < 6; i++) begin
      press(code[i], 1'b0, $urandom_range(1, 4), 1'($urandom_range(0, 1)), 1'b0);
      chk("code_contagem", int'(contagem), i + 1);
    end
    chk("code_completa", int'(completa), 1);
    press(4'd3, 1'b0, 2, 1'b0, 1'b0);
    chk("sat_digito", int'(digito), 3);
    chk("sat_contagem", int'(contagem), ND);

    // limpa coinciding with acceptance, then limpa alone.
    press(4'd4, 1'b1, 2, 1'b0, 1'b1);
    chk("clr_emite_contagem", int'(contagem), 1);
    chk("clr_emite_completa", int'(completa), 0);
    clear_alone();

    // Out-of-BCD value.
    press(4'd12, 1'b0, 2, 1'b0, 1'b0);
    chk("bcd_digito", int'(digito), int'(model_dig));
    chk("bcd_contagem", int'(contagem), model_cnt);

    // Asynchronous reset in the middle of debouncing.
    press(4'd7, 1'b0, 2, 1'b0, 1'b0);
    numero = 4'd6;
    insere = 1'b1;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 reset = 1'b0;
    #1;
    chk("arst_digito", int'(digito), 0);
    chk("arst_valido", int'(valido), 0);
    chk("arst_contagem", int'(contagem), 0);
    chk("arst_completa", int'(completa), 0);
    chk("arst_erro", int'(erro), 0);
    sb.delete();
    model_cnt = 0;
    model_dig = 4'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    e = model_press(4'd6, 1'b0);
    sb.push_back(e);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 5) chk("arst_latency_early", int'(valido), 0);
      if (k == 6) chk("arst_latency_pulse", int'(valido), 1);
    end
    insere = 1'b0;
    repeat (DB + 4) @(negedge clk);
    chk("arst_contagem_after", int'(contagem), 1);

    // Randomised sequence of presses, glitches and clears.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) glitch();
      if ($urandom_range(0, 5) == 0) clear_alone();
      press(4'($urandom_range(0, 15)), 1'b0, $urandom_range(1, 6),
            1'($urandom_range(0, 1)), 1'b0);
    end
    chk("rand_contagem", int'(contagem), model_cnt);
    chk("rand_digito", int'(digito), int'(model_dig));

    repeat (10) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
